// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory port among NUM_REQ requesters.
// Define ARB_TIMEOUT_EN to add a response-wait timeout of TIMEOUT_CYCLES cycles.
module mem_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        mem_valid,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rsp_rdata,
    output logic                        busy
);
    localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     rr_q, rr_d, grant_q, grant_d;
    logic                we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [IDXW-1:0]     win_idx, cand;
    logic                win_found;
    logic                timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter holds zero outside WAIT, so it is already clear on WAIT entry.
    assign cnt_d       = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    // First valid requester scanning from rr_q upward, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDXW'((32'(rr_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready = rst_n ? (NUM_REQ'(1) << win_idx) : '0;
                    grant_d   = win_idx;
                    we_d      = req_we[win_idx];
                    addr_d    = req_addr[win_idx*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[win_idx*DATA_W +: DATA_W];
                    err_d     = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = NUM_REQ'(1) << grant_q;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                rr_d      = (grant_q == IDXW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule
